p2s_rr_scheduler: RTL

//   Shares one LSB-first parallel-to-serial shift engine between NUM_REQ requesters.

---
 rtl/p2s_rr_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/p2s_rr_scheduler.sv
// Round-robin arbiter feeding one shared LSB-first parallel-to-serial shift engine.
// Each granted word is framed with first/last flags and tagged with its channel ID.
module p2s_rr_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1,
  localparam int unsigned CHW       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic                     ser_first,
  output logic                     ser_last,
  output logic [CHW-1:0]           ser_chan,
  output logic                     busy
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_n;
  logic [CHW-1:0]   rr_ptr, rr_ptr_n, chan_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic [CHW-1:0]   pick;
  logic             pick_vld;
  logic [WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*WIDTH +: WIDTH];
  end

  // First valid requester after the last granted one, wrapping at NUM_REQ
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && req_valid[CHW'(idx)]) begin
        pick     = CHW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state, datapath updates and the combinational grant
  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    chan_n    = ser_chan;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          req_ready[pick] = 1'b1;
          shreg_n         = words[pick];
          chan_n          = pick;
          rr_ptr_n        = pick;
          bit_cnt_n       = '0;
          state_n         = SHIFT;
        end
      end
      SHIFT: begin
        shreg_n   = {1'b0, shreg[WIDTH-1:1]};
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == BIT_LAST) begin
          gap_cnt_n = '0;
          state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_cnt_n = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Serial outputs are registered from the next-state view so they align with state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= CHW'(NUM_REQ - 1);
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_chan  <= '0;
      ser_valid <= 1'b0;
      ser_out   <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      ser_chan  <= chan_n;
      ser_valid <= (state_n == SHIFT);
      ser_out   <= (state_n == SHIFT) && shreg_n[0];
      ser_first <= (state_n == SHIFT) && (bit_cnt_n == '0);
      ser_last  <= (state_n == SHIFT) && (bit_cnt_n == BIT_LAST);
      busy      <= (state_n != IDLE);
    end
  end

endmodule
